// File: rtl/hello_scroll_ctrl.sv
// hello_scroll_ctrl: rotation-select controller for the eight-digit HELLO scroller.
// Advances a 3-bit select automatically at TICKS_PER_STEP cycles per step while
// running, toggles run/stop and single-steps from synchronized pushbutton levels,
// and pulses step_tick/wrap alongside every change of the select.
// Optional feature macro: SCROLL_REVERSE_EN (when defined, the dir input selects
// decrementing with a 0->7 wrap; when undefined, dir is ignored and the select
// only increments).
module hello_scroll_ctrl #(
  parameter int TICKS_PER_STEP = 50_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       dir,
  output logic [2:0] bits,
  output logic       running,
  output logic       step_tick,
  output logic       wrap
);

  // Prescaler needs at least one bit even when every cycle is a step.
  localparam int PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_STEP - 1);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Button index 0 is run_btn, index 1 is step_btn.
  logic [1:0] w_btn_async;
  logic [1:0] w_btn_rise;
  logic       w_run_rise;
  logic       w_step_rise;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          w_term;
  logic          w_advance;

  logic [2:0] r_bits;
  logic [2:0] w_bits_next;
  logic       r_step_tick;
  logic       r_wrap;
  logic       w_wrap_next;

  assign w_btn_async = {step_btn, run_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic r_sync1;
      logic r_sync2;
      logic r_prev;

      // Two-flop synchronizer followed by a one-flop history for edge detection.
      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_prev  <= 1'b0;
        end else begin
          r_sync1 <= w_btn_async[gi];
          r_sync2 <= r_sync1;
          r_prev  <= r_sync2;
        end
      end

      assign w_btn_rise[gi] = r_sync2 & ~r_prev;
    end
  endgenerate

  assign w_run_rise  = w_btn_rise[0];
  assign w_step_rise = w_btn_rise[1];

`ifdef SCROLL_REVERSE_EN
  logic r_dir_sync1;
  logic r_dir_sync2;
  logic w_reverse;

  // Direction level is only consulted at an advance, so a plain synchronizer suffices.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_dir_sync1 <= 1'b0;
      r_dir_sync2 <= 1'b0;
    end else begin
      r_dir_sync1 <= dir;
      r_dir_sync2 <= r_dir_sync1;
    end
  end

  assign w_reverse = r_dir_sync2;
`else
  // Direction is not supported in this build; the port is kept for pin compatibility.
  logic w_dir_unused;
  assign w_dir_unused = dir;
`endif

  assign w_term = (r_presc == TERM);

  // FSM state and prescaler registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_presc <= '0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
    end
  end

  // Next state, prescaler and advance request. A toggle always wins over a step;
  // a terminal count still advances on the edge that toggles into STOP.
  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_advance    = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_advance    = w_term;
        w_presc_next = w_term ? '0 : (r_presc + PW'(1));
        if (w_run_rise) begin
          w_state_next = ST_STOP;
          w_presc_next = '0;
        end
      end
      ST_STOP: begin
        w_presc_next = '0;
        if (w_run_rise) begin
          w_state_next = ST_RUN;
        end else if (w_step_rise) begin
          w_advance = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_presc_next = '0;
      end
    endcase
  end

  // Next select value and wrap flag for an advance in the selected direction.
  always_comb begin
    w_bits_next = r_bits;
    w_wrap_next = 1'b0;
    if (w_advance) begin
`ifdef SCROLL_REVERSE_EN
      if (w_reverse) begin
        w_bits_next = r_bits - 3'd1;
        w_wrap_next = (r_bits == 3'd0);
      end else begin
        w_bits_next = r_bits + 3'd1;
        w_wrap_next = (r_bits == 3'd7);
      end
`else
      w_bits_next = r_bits + 3'd1;
      w_wrap_next = (r_bits == 3'd7);
`endif
    end
  end

  // Registered select and the single-cycle pulses that accompany each change.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_bits      <= 3'd0;
      r_step_tick <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_bits      <= w_bits_next;
      r_step_tick <= w_advance;
      r_wrap      <= w_wrap_next;
    end
  end

  assign bits      = r_bits;
  assign running   = (r_state == ST_RUN);
  assign step_tick = r_step_tick;
  assign wrap      = r_wrap;

endmodule
